pci_target_ctrl: RTL and testbench

PCI target-side control sequencer for the 3-word slave storage. It decodes the PCI address phase and claims memory read/write cycles that hit its base address. It runs the DEVSEL#/TRDY#/STOP# handshake and drives the storage's read, write, word-address and byte-enable inputs one data phase at a time. Bursts past the last word end in a target disconnect.

---
 rtl/pci_target_ctrl_if.sv | 27 ++
 rtl/pci_target_ctrl.sv | 92 +++++++++
 tb/tb_pci_target_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pci_target_ctrl_if.sv
// PCI target control bus bundle: PCI-side handshake pins plus the storage-side strobes.
interface pci_target_ctrl_if;
  logic        FRAME_n;
  logic        IRDY_n;
  logic [31:0] AD;
  logic [3:0]  CBE_n;
  logic        store_rdy;
  logic        DEVSEL_n;
  logic        TRDY_n;
  logic        STOP_n;
  logic        ctl_oe;
  logic        ad_oe;
  logic        RE;
  logic        WE;
  logic [1:0]  Address;
  logic [3:0]  BE;

  modport slave (
    input  FRAME_n, IRDY_n, AD, CBE_n, store_rdy,
    output DEVSEL_n, TRDY_n, STOP_n, ctl_oe, ad_oe, RE, WE, Address, BE
  );

  modport master (
    output FRAME_n, IRDY_n, AD, CBE_n, store_rdy,
    input  DEVSEL_n, TRDY_n, STOP_n, ctl_oe, ad_oe, RE, WE, Address, BE
  );
endinterface

// File: rtl/pci_target_ctrl.sv
// PCI target sequencer: claims memory read/write hits on BASE_ADDR and steps the word storage
// one data phase at a time; wait states follow store_rdy, bursts past the last word get STOP#.
module pci_target_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          NWORDS    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pci_target_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, BUSY, CLAIM, XFER, DISC, TURN} state_t;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
  localparam logic [1:0] LAST_WORD  = 2'(NWORDS - 1);

  state_t     state, next_state;
  logic       frame_q;
  logic [1:0] word_ptr;
  logic       is_read;
  logic       devsel_q, trdy_q, stop_q, ctl_oe_q, re_q;
  logic       devsel_d, trdy_d, stop_d, ctl_oe_d, re_d;
  logic       frame_fall, cmd_ok, hit, complete, read_d;

  assign frame_fall = frame_q & ~bus.FRAME_n;
  assign cmd_ok     = (bus.CBE_n == CMD_MEM_RD) || (bus.CBE_n == CMD_MEM_WR);
  assign hit        = (bus.AD[31:4] == BASE_ADDR[31:4]) &&
                      ({30'd0, bus.AD[3:2]} < 32'(NWORDS)) &&
                      (bus.AD[1:0] == 2'b00) && cmd_ok;
  // store_rdy gates completion too: TRDY# is registered and lags a store_rdy drop by a cycle
  assign complete   = (state == XFER) && !trdy_q && !bus.IRDY_n && bus.store_rdy;
  assign read_d     = (state == IDLE) ? (bus.CBE_n == CMD_MEM_RD) : is_read;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_fall) next_state = hit ? CLAIM : BUSY;
      BUSY:    if (bus.FRAME_n && bus.IRDY_n) next_state = IDLE;
      CLAIM:   next_state = XFER;
      XFER: begin
        if (complete) begin
          if (bus.FRAME_n)                next_state = TURN;
          else if (word_ptr == LAST_WORD) next_state = DISC;
        end
      end
      DISC:    if (bus.FRAME_n) next_state = TURN;
      TURN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    devsel_d = !(next_state inside {CLAIM, XFER, DISC});
    trdy_d   = !((state == XFER) && (next_state == XFER) && bus.store_rdy);
    stop_d   = !(next_state == DISC);
    ctl_oe_d = next_state inside {CLAIM, XFER, DISC, TURN};
    re_d     = (next_state inside {CLAIM, XFER}) && read_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame_q  <= 1'b0;  // a FRAME# still low after reset must not look like a new edge
      word_ptr <= 2'd0;
      is_read  <= 1'b0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      ctl_oe_q <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      state    <= next_state;
      frame_q  <= bus.FRAME_n;
      is_read  <= read_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      ctl_oe_q <= ctl_oe_d;
      re_q     <= re_d;
      if ((state == IDLE) && frame_fall) word_ptr <= bus.AD[3:2];
      else if (complete)                 word_ptr <= word_ptr + 2'd1;
    end
  end

  assign bus.DEVSEL_n = devsel_q;
  assign bus.TRDY_n   = trdy_q;
  assign bus.STOP_n   = stop_q;
  assign bus.ctl_oe   = ctl_oe_q;
  assign bus.RE       = re_q;
  assign bus.Address  = word_ptr;
  assign bus.ad_oe    = (state == XFER) && is_read;
  assign bus.WE       = complete && !is_read;
  assign bus.BE       = (state == XFER) ? ~bus.CBE_n : 4'b0000;
endmodule

// File: tb/tb_pci_target_ctrl.sv
// Directed bench for pci_target_ctrl; output vector = {DEVSEL_n,TRDY_n,STOP_n,ctl_oe, ad_oe,RE,WE, Address, BE}.
module tb_pci_target_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pci_target_ctrl_if bus();

  pci_target_ctrl #(.BASE_ADDR(32'h0000_1000), .NWORDS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic i, input logic [31:0] ad, input logic [3:0] cbe);
    bus.FRAME_n = f;
    bus.IRDY_n  = i;
    bus.AD      = ad;
    bus.CBE_n   = cbe;
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {bus.DEVSEL_n, bus.TRDY_n, bus.STOP_n, bus.ctl_oe, bus.ad_oe, bus.RE, bus.WE,
           bus.Address, bus.BE};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    bus.store_rdy = 1'b1;
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    step(); step();
    chk("reset_values", 13'b1110_000_00_0000);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 13'b1110_000_00_0000);

    // single write to word 1
    drive(1'b0, 1'b1, 32'h0000_1004, 4'b0111);
    chk("w1_addr_phase", 13'b1110_000_00_0000);
    step();
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000);
    chk("w1_claim", 13'b0111_000_01_0000);
    step();
    chk("w1_xfer_wait", 13'b0111_000_01_1111);
    step();
    chk("w1_complete", 13'b0011_001_01_1111);
    step();
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    chk("w1_turn", 13'b1111_000_10_0000);
    step();
    chk("w1_idle", 13'b1110_000_10_0000);

    // 3-word burst, byte enables F,2,F, FRAME released on last phase
    drive(1'b0, 1'b1, 32'h0000_1000, 4'b0111);
    step();
    drive(1'b0, 1'b0, 32'h1111_1111, 4'b0000);
    chk("b3_claim", 13'b0111_000_00_0000);
    step();
    chk("b3_xfer_wait", 13'b0111_000_00_1111);
    step();
    chk("b3_word0", 13'b0011_001_00_1111);
    step();
    drive(1'b0, 1'b0, 32'h2222_2222, 4'b1101);
    chk("b3_word1", 13'b0011_001_01_0010);
    step();
    drive(1'b1, 1'b0, 32'h3333_3333, 4'b0000);
    chk("b3_word2", 13'b0011_001_10_1111);
    step();
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    chk("b3_turn_no_stop", 13'b1111_000_11_0000);
    step();
    chk("b3_idle", 13'b1110_000_11_0000);

    // 4-phase burst from word 0 -> disconnect after word 2
    drive(1'b0, 1'b1, 32'h0000_1000, 4'b0111);
    step();
    drive(1'b0, 1'b0, 32'h4444_4444, 4'b0000);
    step();
    chk("b4_xfer_wait", 13'b0111_000_00_1111);
    step();
    chk("b4_word0", 13'b0011_001_00_1111);
    step();
    chk("b4_word1", 13'b0011_001_01_1111);
    step();
    chk("b4_word2", 13'b0011_001_10_1111);
    step();
    chk("b4_disc", 13'b0101_000_11_0000);
    step();
    chk("b4_disc_hold", 13'b0101_000_11_0000);
    drive(1'b1, 1'b0, 32'h0, 4'b0000);
    step();
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    chk("b4_turn", 13'b1111_000_11_0000);
    step();
    chk("b4_idle", 13'b1110_000_11_0000);

    // single read of word 2 with IRDY held off for two cycles
    drive(1'b0, 1'b1, 32'h0000_1008, 4'b0110);
    step();
    drive(1'b0, 1'b1, 32'h0, 4'b0000);
    chk("rd_claim", 13'b0111_010_10_0000);
    step();
    chk("rd_xfer_wait", 13'b0111_110_10_1111);
    step();
    chk("rd_irdy_high", 13'b0011_110_10_1111);
    drive(1'b1, 1'b0, 32'h0, 4'b0000);
    chk("rd_phase", 13'b0011_110_10_1111);
    step();
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    chk("rd_turn", 13'b1111_000_11_0000);
    step();
    chk("rd_idle", 13'b1110_000_11_0000);

    // address miss: BUSY ignores a further FRAME fall
    drive(1'b0, 1'b1, 32'h0000_2000, 4'b0111);
    step();
    drive(1'b0, 1'b0, 32'h0, 4'b0000);
    chk("miss_busy", 13'b1110_000_00_0000);
    step();
    drive(1'b1, 1'b0, 32'h0, 4'b0000);
    step();
    drive(1'b0, 1'b1, 32'h0000_1004, 4'b0111);
    step();
    chk("miss_busy_ignores_fall", 13'b1110_000_00_0000);
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    step();
    chk("miss_exit", 13'b1110_000_00_0000);

    // word index 3 is out of range
    drive(1'b0, 1'b1, 32'h0000_100C, 4'b0111);
    step();
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    chk("word3_no_devsel", 13'b1110_000_11_0000);
    step();
    chk("word3_exit", 13'b1110_000_11_0000);

    // stall with store_rdy low for three cycles, then reset mid-burst
    drive(1'b0, 1'b1, 32'h0000_1000, 4'b0111);
    step();
    drive(1'b0, 1'b0, 32'h5555_5555, 4'b0000);
    step();
    step();
    chk("st_word0", 13'b0011_001_00_1111);
    step();
    bus.store_rdy = 1'b0;
    #1;
    chk("st_drop_no_we", 13'b0011_000_01_1111);
    step();
    chk("st_trdy_high1", 13'b0111_000_01_1111);
    step();
    chk("st_trdy_high2", 13'b0111_000_01_1111);
    step();
    bus.store_rdy = 1'b1;
    #1;
    chk("st_trdy_high3", 13'b0111_000_01_1111);
    step();
    chk("st_word1", 13'b0011_001_01_1111);
    rst_n = 1'b0;
    step();
    chk("st_reset", 13'b1110_000_00_0000);
    rst_n = 1'b1;
    step();
    chk("st_idle_frame_low", 13'b1110_000_00_0000);
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    step();

    // recovery: a fresh single write to word 1
    drive(1'b0, 1'b1, 32'h0000_1004, 4'b0111);
    step();
    drive(1'b1, 1'b0, 32'h6666_6666, 4'b0000);
    chk("rc_claim", 13'b0111_000_01_0000);
    step();
    step();
    chk("rc_complete", 13'b0011_001_01_1111);
    step();
    drive(1'b1, 1'b1, 32'h0, 4'hF);
    step();
    chk("rc_idle", 13'b1110_000_10_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
